// File: rtl/wireframe_scanout_pkg.sv
// Shared display-timing constants and the colour type for the wireframe framebuffer.
// Standard 640x480@60 porch and sync widths live here next to the framebuffer geometry.
package wireframe_scanout_pkg;

  localparam int WIDTH               = 640;
  localparam int HEIGHT              = 480;
  localparam int WIREFRAME_ADDR_SIZE = 19;

  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;

  typedef logic [23:0] Color;

  localparam Color COLOR_BLACK = 24'h000000;

  // Blanking always shows black regardless of the stored bit.
  function automatic Color pixel_color(input logic vis, input logic px_bit,
                                       input Color fg, input Color bg);
    Color c;
    c = COLOR_BLACK;
    if (vis) begin
      c = px_bit ? fg : bg;
    end
    return c;
  endfunction

endpackage

// File: rtl/wireframe_scanout_vga_timing_gen.sv
// Horizontal/vertical raster counters with sync, active-region and frame-position decode.
// Counters only move on i_tick; i_clr parks them at the origin.
module wireframe_scanout_vga_timing_gen
  import wireframe_scanout_pkg::*;
#(
  parameter int H_ACTIVE = WIDTH,
  parameter int H_FP     = wireframe_scanout_pkg::H_FP,
  parameter int H_SYNC   = wireframe_scanout_pkg::H_SYNC,
  parameter int H_BP     = wireframe_scanout_pkg::H_BP,
  parameter int V_ACTIVE = HEIGHT,
  parameter int V_FP     = wireframe_scanout_pkg::V_FP,
  parameter int V_SYNC   = wireframe_scanout_pkg::V_SYNC,
  parameter int V_BP     = wireframe_scanout_pkg::V_BP
) (
  input  logic i_clk,
  input  logic i_n_rst,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_active,
  output logic o_hsync_n,
  output logic o_vsync_n,
  output logic o_origin,
  output logic o_frame_last
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_clr) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_tick) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  assign o_active     = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign o_hsync_n    = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign o_vsync_n    = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
  assign o_origin     = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_frame_last = w_h_last && w_v_last;

endmodule

// File: rtl/wireframe_scanout.sv
// Framebuffer reader: raster-order 1-bit reads, colour mapping and registered display outputs.
// Stage 0 issues the read and captures the timing decode; stage 1 drives the pins.
module wireframe_scanout
  import wireframe_scanout_pkg::*;
#(
  parameter int H_ACTIVE = WIDTH,
  parameter int H_FP     = wireframe_scanout_pkg::H_FP,
  parameter int H_SYNC   = wireframe_scanout_pkg::H_SYNC,
  parameter int H_BP     = wireframe_scanout_pkg::H_BP,
  parameter int V_ACTIVE = HEIGHT,
  parameter int V_FP     = wireframe_scanout_pkg::V_FP,
  parameter int V_SYNC   = wireframe_scanout_pkg::V_SYNC,
  parameter int V_BP     = wireframe_scanout_pkg::V_BP,
  parameter int ADDR_W   = WIREFRAME_ADDR_SIZE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              px_en,
  input  Color              fg_color,
  input  Color              bg_color,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output Color              rgb,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  logic              r_run;
  logic              w_clr;
  logic              w_tick;
  logic              w_active;
  logic              w_hsync_n;
  logic              w_vsync_n;
  logic              w_origin;
  logic              w_frame_last;

  logic [ADDR_W-1:0] r_addr;
  logic              r_wrapped;
  logic              r_de_p0;
  logic              r_hsync_p0;
  logic              r_vsync_p0;
  logic              r_fs_p0;

  Color              r_rgb_p1;
  logic              r_de_p1;
  logic              r_hsync_p1;
  logic              r_vsync_p1;
  logic              r_fs_p1;

  // r_run delays the start by one clk so the counters are known to sit at the origin.
  assign w_clr  = ~enable;
  assign w_tick = r_run & enable & px_en;

  wireframe_scanout_vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk        (clk),
    .i_n_rst      (n_rst),
    .i_clr        (w_clr),
    .i_tick       (w_tick),
    .o_active     (w_active),
    .o_hsync_n    (w_hsync_n),
    .o_vsync_n    (w_vsync_n),
    .o_origin     (w_origin),
    .o_frame_last (w_frame_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_run <= 1'b0;
    end else begin
      r_run <= enable;
    end
  end

  // Stage 0: read request for the current counter position, decode captured alongside it.
  assign rd_en   = w_tick & w_active;
  assign rd_addr = r_addr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_addr     <= '0;
      r_wrapped  <= 1'b0;
      r_de_p0    <= 1'b0;
      r_hsync_p0 <= 1'b1;
      r_vsync_p0 <= 1'b1;
      r_fs_p0    <= 1'b0;
    end else if (!enable) begin
      r_addr     <= '0;
      r_wrapped  <= 1'b0;
      r_de_p0    <= 1'b0;
      r_hsync_p0 <= 1'b1;
      r_vsync_p0 <= 1'b1;
      r_fs_p0    <= 1'b0;
    end else if (w_tick) begin
      r_de_p0    <= w_active;
      r_hsync_p0 <= w_hsync_n;
      r_vsync_p0 <= w_vsync_n;
      r_fs_p0    <= w_origin & r_wrapped;
      if (w_frame_last) begin
        r_addr    <= '0;
        r_wrapped <= 1'b1;
      end else if (w_active) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  // Stage 1: rd_data from the stage-0 read is valid here; colours are sampled now.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rgb_p1   <= COLOR_BLACK;
      r_de_p1    <= 1'b0;
      r_hsync_p1 <= 1'b1;
      r_vsync_p1 <= 1'b1;
      r_fs_p1    <= 1'b0;
    end else if (!enable) begin
      r_rgb_p1   <= COLOR_BLACK;
      r_de_p1    <= 1'b0;
      r_hsync_p1 <= 1'b1;
      r_vsync_p1 <= 1'b1;
      r_fs_p1    <= 1'b0;
    end else if (w_tick) begin
      r_rgb_p1   <= pixel_color(r_de_p0, rd_data, fg_color, bg_color);
      r_de_p1    <= r_de_p0;
      r_hsync_p1 <= r_hsync_p0;
      r_vsync_p1 <= r_vsync_p0;
      r_fs_p1    <= r_fs_p0;
    end else begin
      r_fs_p1 <= 1'b0;
    end
  end

  assign rgb         = r_rgb_p1;
  assign de          = r_de_p1;
  assign hsync       = r_hsync_p1;
  assign vsync       = r_vsync_p1;
  assign frame_start = r_fs_p1;

endmodule

// File: tb/tb_wireframe_scanout.sv
// Scoreboard bench for wireframe_scanout: full 800-clk lines, a short 8-line frame.
// A raster model pushes expected pixels per tick; a negedge monitor pops and compares.
module tb_wireframe_scanout;
  import wireframe_scanout_pkg::*;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NPIX = HA * VA;
  localparam int AW = 19;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic enable = 1'b0;
  logic px_en = 1'b0;
  logic rd_data = 1'b0;
  Color fg_color = 24'h0;
  Color bg_color = 24'h0;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  Color rgb;
  logic de, hsync, vsync, frame_start;

  wireframe_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .ADDR_W(AW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .px_en(px_en),
    .fg_color(fg_color), .bg_color(bg_color),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  bit fb [0:NPIX-1];
  always @(posedge clk) begin
    if (rd_en && int'(rd_addr) < NPIX) rd_data <= fb[rd_addr];
  end

  typedef struct { bit de; bit hs; bit vs; bit fs; int addr; } exp_t;
  localparam exp_t IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, addr: 0};

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Raster position p = v*HT + h of the pixel currently addressed.
  function automatic exp_t pix_exp(input int p, input bit wrapped);
    exp_t e;
    int h, v;
    h = p % HT;
    v = p / HT;
    e.de = (h < HA) && (v < VA);
    e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
    e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
    e.fs = (p == 0) && wrapped;
    e.addr = v * HA + h;
    return e;
  endfunction

  exp_t q[$];
  int   m_pix = 0;
  bit   m_run = 1'b0, m_wrapped = 1'b0;
  bit   last_tick = 1'b0, last_clr = 1'b1;
  Color m_fg = 24'h0, m_bg = 24'h0;

  // Reference model: one entry pushed per pixel-clock tick.
  always @(posedge clk) begin
    bit tick;
    tick = m_run && enable && px_en && n_rst;
    last_tick = tick;
    last_clr = !n_rst || !enable;
    m_fg = fg_color;
    m_bg = bg_color;
    if (last_clr) begin
      q.delete();
      q.push_back(IDLE);
      m_pix = 0;
      m_wrapped = 1'b0;
    end else if (tick) begin
      q.push_back(pix_exp(m_pix, m_wrapped));
      if (m_pix == FRAME - 1) begin
        m_pix = 0;
        m_wrapped = 1'b1;
      end else begin
        m_pix++;
      end
    end
    m_run = n_rst && enable;
  end

  exp_t cur = IDLE;
  Color cur_rgb = 24'h0;

  // Monitor: compares pins on the falling edge after each update.
  always @(negedge clk) begin
    exp_t nx;
    bit exp_rd;
    if (last_clr) begin
      cur = IDLE;
      cur_rgb = 24'h0;
      chk("idle_de", int'(de), 0);
      chk("idle_hsync", int'(hsync), 1);
      chk("idle_vsync", int'(vsync), 1);
      chk("idle_rgb", int'(rgb), 0);
      chk("idle_fs", int'(frame_start), 0);
    end else if (last_tick) begin
      if (q.size() < 2) begin
        chk("scoreboard_depth", q.size(), 2);
      end else begin
        cur = q.pop_front();
        cur_rgb = !cur.de ? 24'h0 : (fb[cur.addr] ? m_fg : m_bg);
        chk("de", int'(de), int'(cur.de));
        chk("hsync", int'(hsync), int'(cur.hs));
        chk("vsync", int'(vsync), int'(cur.vs));
        chk("frame_start", int'(frame_start), int'(cur.fs));
        chk("rgb", int'(rgb), int'(cur_rgb));
      end
    end else begin
      chk("hold_de", int'(de), int'(cur.de));
      chk("hold_hsync", int'(hsync), int'(cur.hs));
      chk("hold_vsync", int'(vsync), int'(cur.vs));
      chk("hold_rgb", int'(rgb), int'(cur_rgb));
      chk("hold_fs", int'(frame_start), 0);
    end
    nx = pix_exp(m_pix, 1'b0);
    exp_rd = m_run && enable && px_en && n_rst && nx.de;
    chk("rd_en", int'(rd_en), int'(exp_rd));
    if (exp_rd) chk("rd_addr", int'(rd_addr), nx.addr);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    int cnt, de_cnt, rd_cnt, hs_low, vs_low, prev_addr, wrap_prev;
    int de_fall, hs_fall, first_addr;
    bit prev_de, prev_hs, have_prev;

    for (int i = 0; i < NPIX; i++) fb[i] = i[0];
    fg_color = 24'hFF0000;
    bg_color = 24'h0000FF;

    repeat (5) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (100) @(posedge clk);
    #1 enable = 1'b1;
    px_en = 1'b1;

    // Frame measurement with px_en held high.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (frame_start) found = 1'b1;
    end
    chk("first_frame_start_seen", int'(found), 1);
    cnt = 0; de_cnt = 0; rd_cnt = 0; hs_low = 0; vs_low = 0;
    prev_addr = -1; wrap_prev = -1; de_fall = -1; hs_fall = -1;
    prev_de = de; prev_hs = hsync; found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      cnt++;
      if (de) de_cnt++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (prev_de && !de && de_fall < 0) de_fall = cnt;
      if (prev_hs && !hsync && de_fall >= 0 && hs_fall < 0) hs_fall = cnt;
      prev_de = de;
      prev_hs = hsync;
      if (rd_en) begin
        if (rd_addr == '0 && prev_addr >= 0) wrap_prev = prev_addr;
        prev_addr = int'(rd_addr);
        rd_cnt++;
      end
      if (frame_start) found = 1'b1;
    end
    chk("frame_period_clks", cnt, FRAME);
    chk("de_clks_per_frame", de_cnt, NPIX);
    chk("rd_en_per_frame", rd_cnt, NPIX);
    chk("hsync_low_clks", hs_low, VT * HS);
    chk("vsync_low_clks", vs_low, VS * HT);
    chk("hsync_after_de_fall", hs_fall - de_fall, HF);
    chk("last_addr_before_wrap", wrap_prev, NPIX - 1);

    // Random image, px_en every other clk.
    @(posedge clk);
    #1 enable = 1'b0;
    for (int i = 0; i < NPIX; i++) fb[i] = ($urandom_range(1) == 1);
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    fg_color = 24'($urandom);
    bg_color = 24'($urandom);
    de_fall = -1; hs_fall = -1; cnt = 0;
    for (int i = 0; i < 4 * FRAME + 100; i++) begin
      @(posedge clk);
      #1 px_en = ~px_en;
      if ((i % 997) == 0) fg_color = 24'($urandom);
      @(negedge clk);
      cnt++;
      if (frame_start) begin
        if (de_fall < 0) de_fall = cnt;
        else if (hs_fall < 0) hs_fall = cnt;
      end
    end
    chk("half_rate_frame_period", hs_fall - de_fall, 2 * FRAME);

    // Random px_en, enable dropped at pixel (300, 2) for 5 clks.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(posedge clk);
      #1 px_en = ($urandom_range(2) != 0);
      if ($urandom_range(40) == 0) bg_color = 24'($urandom);
      if (m_pix == 2 * HT + 300) found = 1'b1;
    end
    chk("reached_drop_point", int'(found), 1);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 enable = 1'b1;
    px_en = 1'b1;
    // Arm clk, pixel-0 read tick, one frame, output tick, plus the sampling offset.
    cnt = 0; found = 1'b0; first_addr = -1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      cnt++;
      if (rd_en && first_addr < 0) first_addr = int'(rd_addr);
      if (frame_start) found = 1'b1;
    end
    chk("first_addr_after_restart", first_addr, 0);
    chk("restart_to_frame_start", cnt, FRAME + 4);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1 px_en = ($urandom_range(3) != 0);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
